rdma_sq_dm_cmd_scheduler: RTL and testbench

- Takes decoded RDMA SQ entries from the SQ-entry AXIS parser, which emits one-cycle valid pulses with no backpressure.
- Buffers entries in a small FIFO and splits each transfer into chunked AXI DataMover MM2S commands, issued one at a time.
- Checks every DataMover status word before issuing the next chunk.
- Returns one completion record per SQ entry to the completion-queue writer.

---
 rtl/rdma_sq_dm_cmd_scheduler_if.sv | 46 ++++
 rtl/rdma_sq_dm_cmd_scheduler.sv | 158 +++++++++++++++
 tb/tb_rdma_sq_dm_cmd_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdma_sq_dm_cmd_scheduler_if.sv
// Handshake and bus signals between the SQ command scheduler and its neighbours:
// SQ-entry parser, DataMover command/status streams and the completion-queue writer.
interface rdma_sq_dm_cmd_scheduler_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [31:0]         rdma_id;
  logic [15:0]         rdma_opcode;
  logic [63:0]         rdma_local_key;
  logic [127:0]        rdma_btt;
  logic                rdma_entry_valid;

  logic [ADDR_W+39:0]  m_cmd_tdata;
  logic                m_cmd_tvalid;
  logic                m_cmd_tready;

  logic [7:0]          s_sts_tdata;
  logic                s_sts_tvalid;
  logic                s_sts_tready;

  logic [31:0]         cpl_id;
  logic [1:0]          cpl_code;
  logic [7:0]          cpl_dm_sts;
  logic [31:0]         cpl_bytes;
  logic                cpl_valid;
  logic                cpl_ready;

  modport master (
    input  rdma_id, rdma_opcode, rdma_local_key, rdma_btt, rdma_entry_valid,
    output m_cmd_tdata, m_cmd_tvalid,
    input  m_cmd_tready,
    input  s_sts_tdata, s_sts_tvalid,
    output s_sts_tready,
    output cpl_id, cpl_code, cpl_dm_sts, cpl_bytes, cpl_valid,
    input  cpl_ready
  );

  modport slave (
    output rdma_id, rdma_opcode, rdma_local_key, rdma_btt, rdma_entry_valid,
    input  m_cmd_tdata, m_cmd_tvalid,
    output m_cmd_tready,
    output s_sts_tdata, s_sts_tvalid,
    input  s_sts_tready,
    input  cpl_id, cpl_code, cpl_dm_sts, cpl_bytes, cpl_valid,
    output cpl_ready
  );
endinterface

// File: rtl/rdma_sq_dm_cmd_scheduler.sv
// RDMA SQ -> AXI DataMover MM2S command scheduler.
// Buffers SQ entries, splits writes into CHUNK_BYTES commands (one outstanding),
// checks each status word and returns one completion record per entry.
module rdma_sq_dm_cmd_scheduler #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CHUNK_BYTES = 65536,
  parameter logic [15:0] OP_WRITE    = 16'h0001
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  rdma_sq_dm_cmd_scheduler_if.master  bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow_err,
  output logic                        busy
);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam logic [31:0] CHUNK = 32'(CHUNK_BYTES);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_STS, CPL} state_t;
  state_t state, state_nxt;

  logic [31:0]       fifo_id   [FIFO_DEPTH];
  logic [15:0]       fifo_op   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_len  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, push, pop;

  logic [31:0]       id_r, rem_r, bytes_r, cur_btt;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        tag_r;
  logic [7:0]        sts_r;
  logic [1:0]        code_r;
  logic              eof, sts_hs, tag_bad, dm_bad;
  logic              unused_bits;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign push    = bus.rdma_entry_valid && !full;
  assign pop     = (state == IDLE) && (count != '0);
  assign cur_btt = (rem_r > CHUNK) ? CHUNK : rem_r;
  assign eof     = (rem_r <= CHUNK);
  assign sts_hs  = bus.s_sts_tvalid && bus.s_sts_tready;
  assign tag_bad = (bus.s_sts_tdata[3:0] != tag_r);
  assign dm_bad  = !bus.s_sts_tdata[7] || (bus.s_sts_tdata[6:4] != 3'b000);
  assign unused_bits = ^{bus.rdma_local_key[63:ADDR_W], bus.rdma_btt[127:32]};

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (bus.rdma_entry_valid && full) overflow_err <= 1'b1;
    end
  end

  // FIFO storage (contents are don't-care while empty)
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_id[wr_ptr]   <= bus.rdma_id;
      fifo_op[wr_ptr]   <= bus.rdma_opcode;
      fifo_addr[wr_ptr] <= bus.rdma_local_key[ADDR_W-1:0];
      fifo_len[wr_ptr]  <= bus.rdma_btt[31:0];
    end
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt        = state;
    bus.m_cmd_tvalid = 1'b0;
    bus.s_sts_tready = 1'b0;
    bus.cpl_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          if (fifo_op[rd_ptr] != OP_WRITE || fifo_len[rd_ptr] == '0) state_nxt = CPL;
          else                                                        state_nxt = CMD;
        end
      end
      CMD: begin
        bus.m_cmd_tvalid = 1'b1;
        if (bus.m_cmd_tready) state_nxt = WAIT_STS;
      end
      WAIT_STS: begin
        bus.s_sts_tready = 1'b1;
        if (bus.s_sts_tvalid) begin
          if (tag_bad || dm_bad || rem_r == cur_btt) state_nxt = CPL;
          else                                        state_nxt = CMD;
        end
      end
      CPL: begin
        bus.cpl_valid = 1'b1;
        if (bus.cpl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers for the entry in flight
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_r    <= '0;
      addr_r  <= '0;
      rem_r   <= '0;
      bytes_r <= '0;
      tag_r   <= '0;
      sts_r   <= '0;
      code_r  <= '0;
    end else begin
      if (pop) begin
        id_r    <= fifo_id[rd_ptr];
        addr_r  <= fifo_addr[rd_ptr];
        rem_r   <= fifo_len[rd_ptr];
        bytes_r <= '0;
        tag_r   <= '0;
        sts_r   <= '0;
        code_r  <= (fifo_op[rd_ptr] != OP_WRITE) ? 2'd1 : 2'd0;
      end else if (state == WAIT_STS && sts_hs) begin
        sts_r <= bus.s_sts_tdata;
        if (tag_bad) begin
          code_r <= 2'd3;
        end else if (dm_bad) begin
          code_r <= 2'd2;
        end else begin
          bytes_r <= bytes_r + cur_btt;
          rem_r   <= rem_r - cur_btt;
          addr_r  <= addr_r + ADDR_W'(cur_btt);
          tag_r   <= tag_r + 4'd1;
        end
      end
    end
  end

  // Command word is forced to zero outside CMD so TYPE does not leak out of reset
  assign bus.m_cmd_tdata = (state == CMD) ?
    {4'h0, tag_r, addr_r, 1'b0, eof, 6'h00, 1'b1, cur_btt[22:0]} : '0;

  assign bus.cpl_id     = id_r;
  assign bus.cpl_code   = code_r;
  assign bus.cpl_dm_sts = sts_r;
  assign bus.cpl_bytes  = bytes_r;
  assign fifo_count     = count;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_rdma_sq_dm_cmd_scheduler.sv
// Self-checking bench for rdma_sq_dm_cmd_scheduler: directed scenarios plus
// randomized entries checked against a closed-form chunking model.
module tb_rdma_sq_dm_cmd_scheduler;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CHUNK      = 65536;
  localparam logic [15:0] OPW        = 16'h0001;

  typedef struct {
    logic [31:0] id;
    logic [15:0] op;
    logic [31:0] addr;
    logic [31:0] len;
    int          err_at;   // chunk index that receives err_sts, -1 for none
    logic [7:0]  err_sts;
  } entry_t;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [2:0] fifo_count;
  logic       overflow_err, busy;
  int unsigned tests = 0;
  int unsigned fails = 0;

  rdma_sq_dm_cmd_scheduler_if #(.ADDR_W(ADDR_W)) bus();

  rdma_sq_dm_cmd_scheduler #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CHUNK_BYTES(CHUNK), .OP_WRITE(OPW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus),
    .fifo_count(fifo_count), .overflow_err(overflow_err), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chunk k of a transfer: every chunk is CHUNK bytes except the remainder in the last
  function automatic logic [ADDR_W+39:0] exp_cmd(input logic [31:0] base, input int k,
                                                 input logic [31:0] len);
    longint unsigned off, left;
    logic [22:0] btt;
    logic [31:0] a;
    logic [3:0]  tag;
    logic        eof;
    off  = longint'(k) * CHUNK;
    left = longint'(len) - off;
    btt  = (left > CHUNK) ? 23'(CHUNK) : 23'(left);
    a    = 32'(longint'(base) + off);
    tag  = 4'(k % 16);
    eof  = (left <= CHUNK);
    return {4'h0, tag, a, 1'b0, eof, 6'h00, 1'b1, btt};
  endfunction

  function automatic entry_t mk_entry();
    entry_t e;
    int unsigned n;
    logic [3:0] tag;
    e.id   = $urandom();
    e.addr = $urandom();
    e.op   = ($urandom_range(0, 9) == 0) ? 16'(2 + $urandom_range(0, 500)) : OPW;
    case ($urandom_range(0, 5))
      0:       e.len = 0;
      1:       e.len = $urandom_range(1, 300);
      2:       e.len = CHUNK - 1 + $urandom_range(0, 2);
      default: e.len = $urandom_range(1, 4 * CHUNK);
    endcase
    e.err_at  = -1;
    e.err_sts = 8'h00;
    n = (e.len + CHUNK - 1) / CHUNK;
    if (e.op == OPW && n > 0 && $urandom_range(0, 2) == 0) begin
      e.err_at = int'($urandom_range(0, n - 1));
      tag = 4'(e.err_at % 16);
      case ($urandom_range(0, 4))
        0:       e.err_sts = {4'hC, tag};
        1:       e.err_sts = {4'h9, tag};
        2:       e.err_sts = {4'hA, tag};
        3:       e.err_sts = {4'h0, tag};
        default: e.err_sts = {4'h8, tag ^ 4'($urandom_range(1, 15))};
      endcase
    end
    return e;
  endfunction

  task automatic drive_entry(input entry_t e);
    bus.rdma_id          = e.id;
    bus.rdma_opcode      = e.op;
    bus.rdma_local_key   = {32'($urandom()), e.addr};
    bus.rdma_btt         = {32'($urandom()), 32'($urandom()), 32'($urandom()), e.len};
    bus.rdma_entry_valid = 1'b1;
    step();
    bus.rdma_entry_valid = 1'b0;
  endtask

  task automatic wait_event();
    int unsigned n = 0;
    while (bus.m_cmd_tvalid !== 1'b1 && bus.cpl_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Plays DataMover and CQ writer for one entry and checks every command and the completion
  task automatic service(input entry_t e);
    int n, k, hold;
    longint unsigned left;
    logic [31:0] btt, exp_bytes;
    logic [1:0]  exp_code;
    logic [7:0]  exp_sts, sts;
    logic [3:0]  tag;
    logic [ADDR_W+39:0] exp_c;
    bit done;
    n = (e.op != OPW) ? 0 : int'((longint'(e.len) + CHUNK - 1) / CHUNK);
    exp_code  = (e.op != OPW) ? 2'd1 : 2'd0;
    exp_bytes = 0;
    exp_sts   = 8'h00;
    k = 0;
    done = 0;
    while (!done && k < n) begin
      left  = longint'(e.len) - longint'(k) * CHUNK;
      btt   = (left > CHUNK) ? CHUNK : 32'(left);
      tag   = 4'(k % 16);
      exp_c = exp_cmd(e.addr, k, e.len);
      wait_event();
      check("cmd_valid", bus.m_cmd_tvalid, 1);
      if (bus.m_cmd_tvalid !== 1'b1) begin
        done = 1;
      end else begin
        check("cmd_tdata", bus.m_cmd_tdata, exp_c);
        check("sts_ready_in_cmd", bus.s_sts_tready, 0);
        hold = $urandom_range(0, 2);
        repeat (hold) begin
          step();
          check("cmd_hold", {bus.m_cmd_tvalid, bus.m_cmd_tdata}, {1'b1, exp_c});
        end
        bus.m_cmd_tready = 1'b1;
        step();
        bus.m_cmd_tready = 1'b0;
        check("sts_ready_in_wait", bus.s_sts_tready, 1);
        repeat ($urandom_range(0, 2)) step();
        sts = (k == e.err_at) ? e.err_sts : {4'h8, tag};
        bus.s_sts_tvalid = 1'b1;
        bus.s_sts_tdata  = sts;
        step();
        bus.s_sts_tvalid = 1'b0;
        bus.s_sts_tdata  = 8'h00;
        exp_sts = sts;
        if (sts[3:0] != tag) begin
          exp_code = 2'd3;
          done = 1;
        end else if (!sts[7] || sts[6:4] != 3'b000) begin
          exp_code = 2'd2;
          done = 1;
        end else begin
          exp_bytes += btt;
          k++;
        end
      end
    end
    wait_event();
    check("cpl_valid", bus.cpl_valid, 1);
    check("no_cmd_at_cpl", bus.m_cmd_tvalid, 0);
    hold = $urandom_range(0, 3);
    for (int h = 0; h <= hold; h++) begin
      check("cpl_id", bus.cpl_id, e.id);
      check("cpl_code", bus.cpl_code, exp_code);
      check("cpl_bytes", bus.cpl_bytes, exp_bytes);
      check("cpl_dm_sts", bus.cpl_dm_sts, exp_sts);
      if (h < hold) begin
        step();
        check("cpl_hold_valid", bus.cpl_valid, 1);
      end
    end
    bus.cpl_ready = 1'b1;
    step();
    bus.cpl_ready = 1'b0;
    check("cpl_dropped", bus.cpl_valid, 0);
    check("idle_after_cpl", busy, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_ovf"}, overflow_err, 0);
    check({tag, "_cmd_valid"}, bus.m_cmd_tvalid, 0);
    check({tag, "_cmd_data"}, bus.m_cmd_tdata, 0);
    check({tag, "_sts_ready"}, bus.s_sts_tready, 0);
    check({tag, "_cpl_valid"}, bus.cpl_valid, 0);
    check({tag, "_cpl_fields"}, {bus.cpl_id, bus.cpl_code, bus.cpl_dm_sts, bus.cpl_bytes}, 0);
  endtask

  initial begin
    entry_t e, e2, q[$];
    entry_t ov[6];
    int unsigned b, seen;

    bus.rdma_id = 0; bus.rdma_opcode = 0; bus.rdma_local_key = 0; bus.rdma_btt = 0;
    bus.rdma_entry_valid = 0; bus.m_cmd_tready = 0; bus.s_sts_tdata = 0;
    bus.s_sts_tvalid = 0; bus.cpl_ready = 0;
    ARESET = 1'b1;
    repeat (3) step();
    check_cleared("reset");
    ARESET = 1'b0;
    step();

    // Single write with latency check
    e = '{32'h11, OPW, 32'h1000_0000, 32'd256, -1, 8'h00};
    drive_entry(e);
    check("lat_n1_valid", bus.m_cmd_tvalid, 0);
    check("lat_n1_count", fifo_count, 1);
    step();
    check("lat_n2_valid", bus.m_cmd_tvalid, 1);
    service(e);

    // Chunking, DM error on second chunk, tag mismatch on first
    service_pair_free: begin
      e = '{32'h22, OPW, 32'h0, 32'h20010, -1, 8'h00};
      drive_entry(e); service(e);
      e = '{32'h33, OPW, 32'h0, 32'h20010, 1, 8'hC1};
      drive_entry(e); service(e);
      e = '{32'h44, OPW, 32'h2000, 32'h20010, 0, 8'h85};
      drive_entry(e); service(e);
    end

    // No-transfer entries back to back
    e  = '{32'h55, 16'h0005, 32'h3000, 32'd100, -1, 8'h00};
    e2 = '{32'h66, OPW, 32'h4000, 32'd0, -1, 8'h00};
    drive_entry(e); drive_entry(e2);
    service(e); service(e2);

    // Chunk boundaries, tag wrap and address wrap
    e = '{32'h70, OPW, 32'h5000, CHUNK, -1, 8'h00};
    drive_entry(e); service(e);
    e = '{32'h71, OPW, 32'h6000, CHUNK + 1, -1, 8'h00};
    drive_entry(e); service(e);
    e = '{32'h77, OPW, 32'hFFFF_8000, 17 * CHUNK + 5, -1, 8'h00};
    drive_entry(e); service(e);

    // Randomized batches, completions expected in push order
    repeat (10) begin
      b = $urandom_range(1, 3);
      repeat (b) begin
        e = mk_entry();
        q.push_back(e);
        drive_entry(e);
      end
      while (q.size() > 0) service(q.pop_front());
    end

    // Overflow with the command stream stalled
    for (int i = 0; i < 6; i++) begin
      ov[i] = mk_entry();
      ov[i].op = OPW;
      ov[i].len = $urandom_range(1, 2 * CHUNK);
      ov[i].err_at = -1;
      ov[i].id = 32'hA0 + 32'(i);
    end
    for (int i = 0; i < 6; i++) drive_entry(ov[i]);
    check("ovf_count", fifo_count, FIFO_DEPTH);
    check("ovf_flag", overflow_err, 1);
    check("ovf_busy", busy, 1);
    check("ovf_cmd_pending", bus.m_cmd_tvalid, 1);
    for (int i = 0; i < 5; i++) service(ov[i]);
    repeat (5) step();
    check("ovf_drained_busy", busy, 0);
    check("ovf_drained_count", fifo_count, 0);
    check("ovf_no_sixth", {bus.m_cmd_tvalid, bus.cpl_valid}, 0);
    check("ovf_sticky", overflow_err, 1);

    // Reset while waiting for status, with another entry queued
    e  = '{32'hB1, OPW, 32'h7000, 32'd64, -1, 8'h00};
    e2 = '{32'hB2, OPW, 32'h8000, 32'd64, -1, 8'h00};
    drive_entry(e); drive_entry(e2);
    wait_event();
    check("rst_cmd_valid", bus.m_cmd_tvalid, 1);
    bus.m_cmd_tready = 1'b1;
    step();
    bus.m_cmd_tready = 1'b0;
    check("rst_in_wait", bus.s_sts_tready, 1);
    check("rst_queued", fifo_count, 1);
    ARESET = 1'b1;
    step();
    check_cleared("midrst");
    ARESET = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (bus.cpl_valid !== 1'b0 || bus.m_cmd_tvalid !== 1'b0) seen++;
    end
    check("midrst_silent", seen, 0);

    // Recovery after reset
    e = '{32'hC3, OPW, 32'h9000, 32'h18000, -1, 8'h00};
    drive_entry(e); service(e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
